sprite_scheduler: RTL and testbench

- Upstream feeder for the frame-buffer graphics stage.
- Holds a table of up to MAX_SPRITES on-screen objects, written by game logic.
- On every frame boundary (frame_count change) it walks the table once and issues each active, on-canvas sprite over the sprite_valid/sprite_ready handshake.
- It resolves each sprite's animation frame number from a global animation step counter.

---
 rtl/sprite_scheduler.sv | 220 ++++++++++++++++++++++
 tb/tb_sprite_scheduler.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_scheduler.sv
// Sprite table plus a once-per-frame walker that issues each active, on-canvas entry to the
// frame-buffer graphics stage with its animation frame resolved from a global step counter.
module sprite_scheduler #(
    parameter int unsigned MAX_SPRITES   = 16,
    parameter int unsigned NUM_FRAMES    = 512,
    parameter int unsigned CANVAS_WIDTH  = 360,
    parameter int unsigned CANVAS_HEIGHT = 720,
    parameter int unsigned ANIM_DIV      = 4,
    localparam int unsigned AW = $clog2(MAX_SPRITES),
    localparam int unsigned XW = $clog2(CANVAS_WIDTH),
    localparam int unsigned YW = $clog2(CANVAS_HEIGHT),
    localparam int unsigned FW = $clog2(NUM_FRAMES)
) (
    input  logic          clk_pixel,
    input  logic          sys_rst,
    input  logic [5:0]    frame_count,
    input  logic          tbl_we,
    input  logic [AW-1:0] tbl_addr,
    input  logic          tbl_active,
    input  logic [XW-1:0] tbl_x,
    input  logic [YW-1:0] tbl_y,
    input  logic [FW-1:0] tbl_base_frame,
    input  logic [1:0]    tbl_anim_log2,
    input  logic          sprite_ready,
    output logic          sprite_valid,
    output logic [XW-1:0] sprite_x,
    output logic [YW-1:0] sprite_y,
    output logic [FW-1:0] sprite_frame_number,
    output logic          walk_done,
    output logic          frame_overrun
);

    localparam int unsigned IW = $clog2(MAX_SPRITES + 1);
    localparam int unsigned DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    localparam logic [IW-1:0] IdxEnd  = IW'(MAX_SPRITES);
    localparam logic [XW-1:0] XLimit  = XW'(CANVAS_WIDTH);
    localparam logic [YW-1:0] YLimit  = YW'(CANVAS_HEIGHT);
    localparam logic [FW:0]   NumF    = (FW + 1)'(NUM_FRAMES);
    localparam logic [DW-1:0] DivLast = DW'(ANIM_DIV - 1);

    typedef enum logic [2:0] {StIdle, StScan, StWaitRdy, StAck, StBusy} state_e;

    state_e        state_q, state_d;
    logic [5:0]    prev_frame_q;
    logic [IW-1:0] idx_q, idx_d;
    logic          walk_done_q, walk_done_d;
    logic          restart_q, restart_d;
    logic          overrun_q;
    logic [7:0]    anim_step_q, anim_step_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [XW-1:0] out_x_q;
    logic [YW-1:0] out_y_q;
    logic [FW-1:0] out_frame_q;

    logic          ent_active_q [MAX_SPRITES];
    logic [XW-1:0] ent_x_q      [MAX_SPRITES];
    logic [YW-1:0] ent_y_q      [MAX_SPRITES];
    logic [FW-1:0] ent_base_q   [MAX_SPRITES];
    logic [1:0]    ent_log2_q   [MAX_SPRITES];

    logic          new_frame;
    logic [AW-1:0] cur_idx;
    logic          cur_usable;
    logic [2:0]    step_mask;
    logic [FW:0]   frame_sum;
    logic [FW-1:0] cur_frame;
    logic          issue;

    assign new_frame = (frame_count != prev_frame_q);
    assign cur_idx   = idx_q[AW-1:0];

    always_ff @(posedge clk_pixel or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < int'(MAX_SPRITES); i++) begin
                ent_active_q[i] <= 1'b0;
                ent_x_q[i]      <= '0;
                ent_y_q[i]      <= '0;
                ent_base_q[i]   <= '0;
                ent_log2_q[i]   <= '0;
            end
        end else if (tbl_we) begin
            ent_active_q[tbl_addr] <= tbl_active;
            ent_x_q[tbl_addr]      <= tbl_x;
            ent_y_q[tbl_addr]      <= tbl_y;
            ent_base_q[tbl_addr]   <= tbl_base_frame;
            ent_log2_q[tbl_addr]   <= tbl_anim_log2;
        end
    end

    assign cur_usable = ent_active_q[cur_idx] && (ent_x_q[cur_idx] < XLimit) &&
                        (ent_y_q[cur_idx] < YLimit);

    always_comb begin
        step_mask = 3'b000;
        unique case (ent_log2_q[cur_idx])
            2'd0: step_mask = 3'b000;
            2'd1: step_mask = 3'b001;
            2'd2: step_mask = 3'b011;
            2'd3: step_mask = 3'b111;
            default: step_mask = 3'b000;
        endcase
    end

    assign frame_sum = {1'b0, ent_base_q[cur_idx]} +
                       {{(FW - 2){1'b0}}, anim_step_q[2:0] & step_mask};

    always_comb begin
        cur_frame = frame_sum[FW-1:0];
        if (frame_sum >= NumF) begin
            cur_frame = FW'(frame_sum - NumF);
        end
    end

    // A frame change in WAIT_RDY restarts the walk, so it also suppresses the issue.
    assign issue = (state_q == StWaitRdy) && sprite_ready && !new_frame;

    assign sprite_valid        = issue;
    assign sprite_x            = issue ? ent_x_q[cur_idx] : out_x_q;
    assign sprite_y            = issue ? ent_y_q[cur_idx] : out_y_q;
    assign sprite_frame_number = issue ? cur_frame : out_frame_q;
    assign walk_done           = walk_done_q;
    assign frame_overrun       = overrun_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        walk_done_d = walk_done_q;
        restart_d   = restart_q;
        anim_step_d = anim_step_q;
        div_cnt_d   = div_cnt_q;

        if (new_frame) begin
            walk_done_d = 1'b0;
            if (div_cnt_q == DivLast) begin
                div_cnt_d   = '0;
                anim_step_d = anim_step_q + 8'd1;
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                if (new_frame) begin
                    state_d = StScan;
                    idx_d   = '0;
                end
            end
            StScan: begin
                if (new_frame) begin
                    idx_d = '0;
                end else if (idx_q == IdxEnd) begin
                    state_d     = StIdle;
                    walk_done_d = 1'b1;
                end else if (!cur_usable) begin
                    idx_d = idx_q + IW'(1);
                end else begin
                    state_d = StWaitRdy;
                end
            end
            StWaitRdy: begin
                if (new_frame) begin
                    state_d = StScan;
                    idx_d   = '0;
                end else if (sprite_ready) begin
                    state_d = StAck;
                end
            end
            StAck: begin
                if (new_frame) begin
                    restart_d = 1'b1;
                end
                state_d = StBusy;
            end
            StBusy: begin
                // The graphics stage must finish before a restarted walk may issue anything.
                if (sprite_ready) begin
                    state_d   = StScan;
                    idx_d     = (restart_q || new_frame) ? '0 : idx_q + IW'(1);
                    restart_d = 1'b0;
                end else if (new_frame) begin
                    restart_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_pixel or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            prev_frame_q <= '0;
            idx_q        <= '0;
            walk_done_q  <= 1'b1;
            restart_q    <= 1'b0;
            overrun_q    <= 1'b0;
            anim_step_q  <= '0;
            div_cnt_q    <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_frame_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_frame_q <= frame_count;
            idx_q        <= idx_d;
            walk_done_q  <= walk_done_d;
            restart_q    <= restart_d;
            overrun_q    <= new_frame && (state_q != StIdle);
            anim_step_q  <= anim_step_d;
            div_cnt_q    <= div_cnt_d;
            if (issue) begin
                out_x_q     <= ent_x_q[cur_idx];
                out_y_q     <= ent_y_q[cur_idx];
                out_frame_q <= cur_frame;
            end
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Scoreboard bench for sprite_scheduler: directed table contents and frame changes push the
// expected issues; a negedge monitor pops and compares each sprite_valid pulse.
module tb_sprite_scheduler;

    logic       clk_pixel;
    logic       sys_rst;
    logic [5:0] frame_count;
    logic       tbl_we;
    logic [3:0] tbl_addr;
    logic       tbl_active;
    logic [8:0] tbl_x;
    logic [9:0] tbl_y;
    logic [8:0] tbl_base_frame;
    logic [1:0] tbl_anim_log2;
    logic       sprite_ready;
    logic       sprite_valid;
    logic [8:0] sprite_x;
    logic [9:0] sprite_y;
    logic [8:0] sprite_frame_number;
    logic       walk_done;
    logic       frame_overrun;

    typedef struct packed {
        logic [8:0] x;
        logic [9:0] y;
        logic [8:0] f;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   n_ov = 0;
    int   busy_len = 4;
    bit   hold_ready = 1'b0;

    localparam int AnimExp [20] = '{510, 510, 510, 510, 511, 511, 511, 511, 0, 0, 0, 0,
                                    1, 1, 1, 1, 510, 510, 510, 510};

    sprite_scheduler dut (
        .clk_pixel           (clk_pixel),
        .sys_rst             (sys_rst),
        .frame_count         (frame_count),
        .tbl_we              (tbl_we),
        .tbl_addr            (tbl_addr),
        .tbl_active          (tbl_active),
        .tbl_x               (tbl_x),
        .tbl_y               (tbl_y),
        .tbl_base_frame      (tbl_base_frame),
        .tbl_anim_log2       (tbl_anim_log2),
        .sprite_ready        (sprite_ready),
        .sprite_valid        (sprite_valid),
        .sprite_x            (sprite_x),
        .sprite_y            (sprite_y),
        .sprite_frame_number (sprite_frame_number),
        .walk_done           (walk_done),
        .frame_overrun       (frame_overrun)
    );

    initial begin
        clk_pixel = 1'b0;
        forever #5 clk_pixel = ~clk_pixel;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expected issue per sprite_valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_pixel);
            if (!sys_rst && frame_overrun) n_ov++;
            if (!sys_rst && sprite_valid) begin
                n_valid++;
                check("issue_while_ready", int'(sprite_ready), 1);
                if (sb.size() == 0) begin
                    check("unexpected_issue_x", int'(sprite_x), -1);
                end else begin
                    e = sb.pop_front();
                    check("issue_x", int'(sprite_x), int'(e.x));
                    check("issue_y", int'(sprite_y), int'(e.y));
                    check("issue_frame", int'(sprite_frame_number), int'(e.f));
                end
            end
        end
    end

    // Graphics-stage model: drops ready the cycle after an accept, busy for busy_len cycles.
    initial begin
        int busy_cnt = 0;
        int last_nv = 0;
        sprite_ready = 1'b1;
        forever begin
            @(posedge clk_pixel);
            #2;
            if (sys_rst) begin
                sprite_ready = 1'b1;
                busy_cnt     = 0;
                last_nv      = n_valid;
            end else if (n_valid != last_nv) begin
                last_nv      = n_valid;
                sprite_ready = 1'b0;
                busy_cnt     = busy_len;
            end else if (hold_ready) begin
                sprite_ready = 1'b0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) sprite_ready = 1'b1;
            end else begin
                sprite_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic write_entry(input int addr, input bit act, input int x, input int y,
                               input int base, input int lg);
        tbl_addr       = 4'(addr);
        tbl_active     = act;
        tbl_x          = 9'(x);
        tbl_y          = 10'(y);
        tbl_base_frame = 9'(base);
        tbl_anim_log2  = 2'(lg);
        tbl_we         = 1'b1;
        tick();
        tbl_we         = 1'b0;
    endtask

    task automatic push(input int x, input int y, input int f);
        exp_t e;
        e.x = 9'(x);
        e.y = 10'(y);
        e.f = 9'(f);
        sb.push_back(e);
    endtask

    task automatic do_frame();
        frame_count = frame_count + 6'd1;
        tick();
    endtask

    task automatic wait_walk(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (walk_done) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_walk_done"}, int'(done), 1);
        check({name, "_sb_empty"}, sb.size(), 0);
    endtask

    initial begin
        bit found;
        int nv0;

        sys_rst        = 1'b1;
        frame_count    = 6'd0;
        tbl_we         = 1'b0;
        tbl_addr       = '0;
        tbl_active     = 1'b0;
        tbl_x          = '0;
        tbl_y          = '0;
        tbl_base_frame = '0;
        tbl_anim_log2  = '0;
        #1;
        check("rst_valid", int'(sprite_valid), 0);
        check("rst_x", int'(sprite_x), 0);
        check("rst_y", int'(sprite_y), 0);
        check("rst_frame", int'(sprite_frame_number), 0);
        check("rst_walk_done", int'(walk_done), 1);
        check("rst_overrun", int'(frame_overrun), 0);
        tick();
        tick();
        sys_rst = 1'b0;
        tick();

        // Empty table: walk_done returns exactly MAX_SPRITES+1 cycles after the frame change.
        do_frame();
        check("empty_walk_done_low", int'(walk_done), 0);
        repeat (16) tick();
        check("empty_walk_done_t16", int'(walk_done), 0);
        tick();
        check("empty_walk_done_t17", int'(walk_done), 1);
        check("empty_no_issue", n_valid, 0);
        for (int i = 0; i < 14; i++) begin
            do_frame();
            wait_walk("empty", 40);
        end

        // Animation wrap: frame changes 16..35 since reset, ANIM_DIV=4, length 4.
        write_entry(0, 1'b1, 1, 2, 510, 2);
        for (int i = 0; i < 20; i++) begin
            push(1, 2, AnimExp[i]);
            do_frame();
            wait_walk("anim", 200);
        end

        // Three sparse entries with a slow graphics stage.
        busy_len = 64;
        write_entry(0, 1'b1, 10, 20, 5, 0);
        write_entry(3, 1'b1, 100, 300, 40, 0);
        write_entry(7, 1'b1, 359, 719, 511, 0);
        push(10, 20, 5);
        push(100, 300, 40);
        push(359, 719, 511);
        do_frame();
        wait_walk("three", 2000);

        // Off-canvas neighbours are skipped.
        write_entry(1, 1'b1, 360, 5, 1, 0);
        write_entry(2, 1'b1, 5, 720, 2, 0);
        push(10, 20, 5);
        push(100, 300, 40);
        push(359, 719, 511);
        do_frame();
        wait_walk("offcanvas", 2000);
        check("no_overrun_yet", n_ov, 0);

        // Frame change while the graphics stage is busy with entry 2 of 5.
        busy_len = 3;
        write_entry(1, 1'b1, 11, 21, 6, 0);
        write_entry(2, 1'b1, 12, 22, 7, 0);
        write_entry(4, 1'b1, 13, 23, 8, 0);
        write_entry(7, 1'b0, 0, 0, 0, 0);
        push(10, 20, 5);
        push(11, 21, 6);
        push(12, 22, 7);
        do_frame();
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk_pixel);
            if (sprite_valid && sprite_x == 9'd12) begin
                found      = 1'b1;
                hold_ready = 1'b1;
            end
        end
        check("overrun_entry2_seen", int'(found), 1);
        repeat (3) tick();
        nv0 = n_valid;
        push(10, 20, 5);
        push(11, 21, 6);
        push(12, 22, 7);
        push(100, 300, 40);
        push(13, 23, 8);
        do_frame();
        check("overrun_pulse", int'(frame_overrun), 1);
        tick();
        check("overrun_one_cycle", int'(frame_overrun), 0);
        repeat (8) tick();
        check("overrun_no_issue_busy", n_valid, nv0);
        check("overrun_walk_done_low", int'(walk_done), 0);
        hold_ready = 1'b0;
        wait_walk("overrun", 500);
        check("overrun_count", n_ov, 1);

        // Write to entry 4 in the very cycle it is issued.
        push(10, 20, 5);
        push(11, 21, 6);
        push(12, 22, 7);
        push(100, 300, 40);
        push(13, 23, 8);
        do_frame();
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            @(negedge clk_pixel);
            if (sprite_valid && sprite_x == 9'd13) begin
                found          = 1'b1;
                tbl_addr       = 4'd4;
                tbl_active     = 1'b1;
                tbl_x          = 9'd14;
                tbl_y          = 10'd24;
                tbl_base_frame = 9'd9;
                tbl_anim_log2  = 2'd0;
                tbl_we         = 1'b1;
            end
        end
        check("samecycle_entry4_seen", int'(found), 1);
        tick();
        tbl_we = 1'b0;
        wait_walk("samecycle_old", 500);
        push(10, 20, 5);
        push(11, 21, 6);
        push(12, 22, 7);
        push(100, 300, 40);
        push(14, 24, 9);
        do_frame();
        wait_walk("samecycle_new", 500);

        // Asynchronous reset while parked in WAIT_RDY on entry 0.
        hold_ready = 1'b1;
        tick();
        nv0 = n_valid;
        do_frame();
        tick();
        tick();
        check("waitrdy_walk_done_low", int'(walk_done), 0);
        check("waitrdy_x_held", int'(sprite_x), 14);
        sys_rst     = 1'b1;
        frame_count = 6'd0;
        #1;
        check("midrst_valid", int'(sprite_valid), 0);
        check("midrst_x", int'(sprite_x), 0);
        check("midrst_y", int'(sprite_y), 0);
        check("midrst_frame", int'(sprite_frame_number), 0);
        check("midrst_walk_done", int'(walk_done), 1);
        hold_ready = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        repeat (20) tick();
        check("postrst_no_issue", n_valid, nv0);
        check("postrst_walk_done", int'(walk_done), 1);

        // First frame after reset: table was cleared and anim_step restarts at 0.
        write_entry(0, 1'b1, 5, 6, 510, 2);
        push(5, 6, 510);
        do_frame();
        wait_walk("postrst", 200);
        check("final_overrun_count", n_ov, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
